// File: rtl/sram_bank.sv
// Single-port SRAM bank with burst read/write access and per-byte write enables.
// Defining SRAM_BANK_PARITY_EN adds one even-parity bit per byte and drives par_err on reads.
module sram_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rlast,
    output logic                  busy,
    output logic                  par_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] ptr_q,     ptr_d;
    logic [LEN_W-1:0]  cnt_q,     cnt_d;
    logic              rvalid_q,  rvalid_d;
    logic              rlast_q,   rlast_d;
    logic [DATA_W-1:0] rdata_q,   rdata_d;
    logic              par_err_q, par_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              wr_fire;
    logic              rd_par_err;

    assign req_ready = (state_q == IDLE);
    assign wready    = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign wr_fire   = (state_q == WRITE) && wvalid;
    assign rd_word   = mem_q[ptr_q];

    assign rvalid    = rvalid_q;
    assign rlast     = rlast_q;
    assign rdata     = rdata_q;
    assign par_err   = par_err_q;

    // The counter holds beats remaining minus one, so zero marks the final beat of a burst.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        rdata_d   = rdata_q;
        par_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    ptr_d   = req_addr;
                    cnt_d   = req_len;
                    state_d = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wvalid) begin
                    ptr_d = ptr_q + 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            READ: begin
                rvalid_d  = 1'b1;
                rdata_d   = rd_word;
                rlast_d   = (cnt_q == '0);
                par_err_d = rd_par_err;
                ptr_d     = ptr_q + 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            par_err_q <= par_err_d;
        end
    end

    // Storage is never cleared by reset; reset only blocks a write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wbe[b]) begin
                    mem_q[ptr_q][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef SRAM_BANK_PARITY_EN
    logic [BYTES-1:0] par_mem_q [DEPTH];
    logic [BYTES-1:0] rd_par_calc;
    logic [BYTES-1:0] wr_par;

    always_comb begin
        for (int b = 0; b < BYTES; b++) begin
            rd_par_calc[b] = ^rd_word[8*b +: 8];
            wr_par[b]      = ^wdata[8*b +: 8];
        end
    end

    assign rd_par_err = |(rd_par_calc ^ par_mem_q[ptr_q]);

    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wbe[b]) begin
                    par_mem_q[ptr_q][b] <= wr_par[b];
                end
            end
        end
    end
`else
    assign rd_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bank.sv
// Self-checking bench for sram_bank: directed scenarios plus randomized bursts
// checked against a flat word-array model of the memory.
module tb_sram_bank;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [LEN_W-1:0]    req_len;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wbe;
    logic                rvalid;
    logic [DATA_W-1:0]   rdata;
    logic                rlast;
    logic                busy;
    logic                par_err;

    sram_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_len  (req_len),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wbe      (wbe),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .rlast    (rlast),
        .busy     (busy),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] modelMem [DEPTH];
    logic [DATA_W-1:0] beatData [8];
    logic [3:0]        beatBe   [8];
    logic              corruptValid = 1'b0;
    logic [ADDR_W-1:0] corruptAddr  = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic driveJunk();
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = ADDR_W'($urandom);
        req_len   = LEN_W'($urandom);
    endtask

    task automatic clearInputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wvalid    = 1'b0;
        wdata     = '0;
        wbe       = '0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (req_ready !== 1'b1) checkOutput("idleTimeout", 64'(req_ready), 64'd1);
    endtask

    task automatic applyStimulusWrite(input logic [ADDR_W-1:0] addr, input int len, input int gap);
        logic [ADDR_W-1:0] a;
        waitIdle();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        req_len   = LEN_W'(len);
        tick();
        req_valid = 1'b0;
        checkOutput("wrBusy", 64'(busy), 64'd1);
        for (int i = 0; i <= len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    wvalid = 1'b0;
                    wdata  = $urandom;
                    wbe    = 4'hF;
                    driveJunk();
                    tick();
                    checkOutput("gapBusy", 64'(busy), 64'd1);
                    checkOutput("gapWready", 64'(wready), 64'd1);
                end
            end
            wvalid = 1'b1;
            wdata  = beatData[i];
            wbe    = beatBe[i];
            driveJunk();
            tick();
            a = addr + ADDR_W'(i);
            for (int b = 0; b < 4; b++) begin
                if (beatBe[i][b]) modelMem[a][8*b +: 8] = beatData[i][8*b +: 8];
            end
        end
        clearInputs();
        checkOutput("wrDoneBusy", 64'(busy), 64'd0);
        checkOutput("wrDoneWready", 64'(wready), 64'd0);
    endtask

    task automatic applyStimulusRead(input logic [ADDR_W-1:0] addr, input int len);
        logic [ADDR_W-1:0] a;
        waitIdle();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        req_len   = LEN_W'(len);
        tick();
        req_valid = 1'b0;
        checkOutput("rdFirstRvalid", 64'(rvalid), 64'd0);
        checkOutput("rdBusy", 64'(busy), 64'd1);
        checkOutput("rdReqReady", 64'(req_ready), 64'd0);
        for (int i = 0; i <= len; i++) begin
            driveJunk();
            wvalid = 1'($urandom_range(0, 1));
            wdata  = $urandom;
            wbe    = 4'hF;
            tick();
            a = addr + ADDR_W'(i);
            checkOutput("rdValid", 64'(rvalid), 64'd1);
            checkOutput("rdData", 64'(rdata), 64'(modelMem[a]));
            checkOutput("rdLast", 64'(rlast), 64'(i == len));
            checkOutput("rdParErr", 64'(par_err), 64'(corruptValid && (a == corruptAddr)));
        end
        clearInputs();
        checkOutput("rdEndReqReady", 64'(req_ready), 64'd1);
        tick();
        a = addr + ADDR_W'(len);
        checkOutput("rdAfterValid", 64'({rvalid, rlast}), 64'd0);
        checkOutput("rdHold", 64'(rdata), 64'(modelMem[a]));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] ra;
        int rl;
        rst = 1'b1;
        clearInputs();
        repeat (3) tick();
        checkOutput("rstReqReady", 64'(req_ready), 64'd1);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstWready", 64'(wready), 64'd0);
        checkOutput("rstRvalid", 64'(rvalid), 64'd0);
        checkOutput("rstRlast", 64'(rlast), 64'd0);
        checkOutput("rstParErr", 64'(par_err), 64'd0);
        checkOutput("rstRdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        tick();

        $display("[TB] preloading memory");
        for (int blk = 0; blk < DEPTH / 8; blk++) begin
            for (int i = 0; i < 8; i++) begin
                beatData[i] = $urandom;
                beatBe[i]   = 4'hF;
            end
            applyStimulusWrite(ADDR_W'(blk * 8), 7, 0);
        end

        $display("[TB] basic burst write/read");
        beatData[0] = 32'h1111_1111; beatData[1] = 32'h2222_2222;
        beatData[2] = 32'h3333_3333; beatData[3] = 32'h4444_4444;
        for (int i = 0; i < 4; i++) beatBe[i] = 4'hF;
        applyStimulusWrite(10'h010, 3, 0);
        applyStimulusRead(10'h010, 3);

        $display("[TB] byte-enable merge");
        beatData[0] = 32'hAABB_CCDD; beatBe[0] = 4'hF;
        applyStimulusWrite(10'h020, 0, 0);
        beatData[0] = 32'h1122_3344; beatBe[0] = 4'h5;
        applyStimulusWrite(10'h020, 0, 0);
        applyStimulusRead(10'h020, 0);
        checkOutput("mergeWord", 64'(rdata), 64'h0000_0000_AA22_CC44);

        $display("[TB] address wrap");
        beatData[0] = 32'hCAFE_0001; beatData[1] = 32'hCAFE_0002;
        beatBe[0] = 4'hF; beatBe[1] = 4'hF;
        applyStimulusWrite(10'h3FF, 1, 0);
        applyStimulusRead(10'h3FF, 1);
        applyStimulusRead(10'h000, 0);
        checkOutput("wrapWord", 64'(rdata), 64'h0000_0000_CAFE_0002);

        $display("[TB] write with wvalid gaps");
        for (int i = 0; i < 4; i++) begin
            beatData[i] = $urandom;
            beatBe[i]   = 4'hF;
        end
        applyStimulusWrite(10'h080, 3, 5);
        applyStimulusRead(10'h07F, 5);

        $display("[TB] reset during read burst");
        waitIdle();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h100; req_len = 3'd7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checkOutput("abortBeat2Valid", 64'(rvalid), 64'd1);
        checkOutput("abortBeat2Data", 64'(rdata), 64'(modelMem[10'h101]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abortRvalid", 64'(rvalid), 64'd0);
        checkOutput("abortRlast", 64'(rlast), 64'd0);
        checkOutput("abortReqReady", 64'(req_ready), 64'd1);
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortRdata", 64'(rdata), 64'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("abortQuiet", 64'({rvalid, rlast}), 64'd0);
        end

        $display("[TB] reset during write burst");
        waitIdle();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h200; req_len = 3'd3;
        tick();
        req_valid = 1'b0;
        wvalid = 1'b1; wdata = 32'h0BAD_F00D; wbe = 4'hF;
        tick();
        modelMem[10'h200] = 32'h0BAD_F00D;
        wdata = 32'hDEAD_BEEF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wvalid = 1'b0;
        checkOutput("wrAbortBusy", 64'(busy), 64'd0);
        tick();
        applyStimulusRead(10'h200, 3);

        $display("[TB] randomized bursts");
        for (int it = 0; it < 60; it++) begin
            ra = ADDR_W'($urandom);
            rl = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) begin
                    beatData[i] = $urandom;
                    beatBe[i]   = 4'($urandom);
                end
                applyStimulusWrite(ra, rl, $urandom_range(0, 3));
                applyStimulusRead(ra, rl);
            end else begin
                applyStimulusRead(ra, rl);
            end
        end

`ifdef SRAM_BANK_PARITY_EN
        $display("[TB] parity error injection");
        beatData[0] = 32'h5A5A_0F0F; beatBe[0] = 4'hF;
        applyStimulusWrite(10'h030, 0, 0);
        applyStimulusRead(10'h030, 0);
        dut.mem_q[10'h030] = dut.mem_q[10'h030] ^ 32'h0000_0100;
        modelMem[10'h030]  = modelMem[10'h030] ^ 32'h0000_0100;
        corruptValid = 1'b1;
        corruptAddr  = 10'h030;
        applyStimulusRead(10'h02F, 2);
        corruptValid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits; legal values are multiples of 8 (byte lanes = DATA_W/8).
REQ-002 SHALL have parameter ADDR_W, default 10, word-address width; depth = 2^ADDR_W words.
REQ-003 SHALL have parameter LEN_W, default 3, burst-length field width; burst beats = req_len+1, i.e. 1..2^LEN_W.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-008 SHALL have port req_we, input, 1, 1 = write burst, 0 = read burst.
REQ-009 SHALL have port req_addr, input, ADDR_W, burst start word address.
REQ-010 SHALL have port req_len, input, LEN_W, beats minus one.
REQ-011 SHALL have port wvalid, input, 1, write beat present.
REQ-012 SHALL have port wready, output, 1, write beat accepted when high with wvalid.
REQ-013 SHALL have port wdata, input, DATA_W, write beat data.
REQ-014 SHALL have port wbe, input, DATA_W/8, per-byte write enables for the beat.
REQ-015 SHALL have port rvalid, output, 1, read beat valid (no backpressure).
REQ-016 SHALL have port rdata, output, DATA_W, read beat data.
REQ-017 SHALL have port rlast, output, 1, high with final read beat.
REQ-018 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-019 SHALL have port par_err, output, 1, parity error on current read beat (see REQ-035).

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ.
REQ-021 SHALL drive req_ready=1 only in IDLE; accept on req_valid&&req_ready, latching addr, we, len into internal pointer and beat counter.
REQ-022 SHALL transition IDLE->WRITE if req_we=1, IDLE->READ if req_we=0, on acceptance.
REQ-023 SHALL drive wready=1 only in WRITE; each accepted beat writes bytes with wbe[i]=1 at pointer, leaves other bytes unchanged, then increments pointer.
REQ-024 SHALL stall WRITE indefinitely while wvalid=0, no pointer or counter change.
REQ-025 SHALL return WRITE->IDLE on the cycle after the final beat is accepted.
REQ-026 SHALL in READ issue one address per cycle for len+1 consecutive cycles; rdata/rvalid appear exactly 1 cycle after each address issue.
REQ-027 SHALL assert rlast with the final rvalid beat only; return READ->IDLE such that req_ready is high the cycle rlast is high.
REQ-028 SHALL wrap the pointer modulo 2^ADDR_W (address 2^ADDR_W-1 followed by 0).
REQ-029 SHALL hold rdata at last value when rvalid=0; rvalid, rlast low outside read beats.
REQ-030 SHALL ignore wvalid/wdata outside WRITE and req_* outside IDLE.
REQ-031 SHALL return read-after-write data of an immediately preceding write burst (no stale read).

Reset
REQ-032 SHALL on rst force state IDLE, req_ready=1 next cycle, wready=0, rvalid=0, rlast=0, busy=0, par_err=0, rdata=0, pointer and counter=0.
REQ-033 SHALL abort any in-flight burst on rst mid-operation: no further writes, pending read beats dropped; memory contents not cleared.
REQ-034 SHALL give rst priority over every other input in the same cycle.

Configuration
REQ-035 SHALL with macro SRAM_BANK_PARITY_EN defined store one even-parity bit per byte on write and assert par_err with rvalid when any byte of the beat mismatches.
REQ-036 SHALL without SRAM_BANK_PARITY_EN store no parity bits and tie par_err to 0.

Verification
REQ-037 SHALL cover: reset, write len=3 at addr 0x010 data 0x11111111..0x44444444 wbe=0xF, read len=3 at 0x010 -> rvalid 4 cycles, data in order, rlast on 4th only.
REQ-038 SHALL cover: write 0xAABBCCDD to 0x020, then write 0x11223344 wbe=0x5 -> read returns 0xAA22CC44.
REQ-039 SHALL cover: write len=1 at addr 0x3FF (ADDR_W=10) -> second beat lands at 0x000, read-back confirms.
REQ-040 SHALL cover: write burst with wvalid low 5 cycles between beats -> busy stays high, no extra writes, correct data.
REQ-041 SHALL cover: rst asserted during 2nd beat of read len=7 -> rvalid low next cycle, req_ready high, no rlast issued.
REQ-042 SHALL cover (SRAM_BANK_PARITY_EN): force-flip one stored data bit at 0x030 -> read asserts par_err=1 on that beat; clean word gives par_err=0.
